// File: rtl/sha256_nonce_sweep.sv
// Fetches the 80-byte header minus nonce, builds the block-1 midstate, then
// compresses block 2 once per nonce index and publishes every resulting state.
module sha256_nonce_sweep #(
    parameter int NUM_OF_WORDS = 19,
    parameter int NUM_NONCES   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] input_addr,
    input  logic [31:0] mem_read_data,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] hout [NUM_NONCES][8]
);
    localparam int RW = $clog2(NUM_OF_WORDS + 2);
    localparam int BW = $clog2(NUM_NONCES + 1);
    localparam int NW = $clog2(NUM_NONCES);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [2:0] {IDLE, READ, INIT, ROUND, ADD} state_t;

    state_t          state;
    logic [RW-1:0]   rd_cnt;
    logic [BW-1:0]   blk;
    logic [NW-1:0]   nidx;
    logic [5:0]      t;
    logic [31:0]     header [NUM_OF_WORDS];
    logic [31:0]     mid [8];
    logic [31:0]     v [8];
    logic [31:0]     w [16];
    logic [31:0]     sum [8];
    logic [31:0]     t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign mem_clk = clk;
    assign mem_we  = 1'b0;
    assign nidx    = NW'(blk - 1'b1);

    always_comb begin
        t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[0];
        t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        // w[i] holds W[t+i]; this produces W[t+16] for the shift-in slot.
        w_new = w[0] + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[9]
              + (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10));
        for (int i = 0; i < 8; i++) begin
            sum[i] = ((blk == '0) ? IV[i] : mid[i]) + v[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b1;
            mem_addr <= '0;
            rd_cnt   <= '0;
            blk      <= '0;
            t        <= '0;
            for (int i = 0; i < NUM_OF_WORDS; i++) header[i] <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                mid[i] <= '0;
                v[i]   <= '0;
            end
            for (int n = 0; n < NUM_NONCES; n++) begin
                for (int i = 0; i < 8; i++) hout[n][i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= input_addr;
                        rd_cnt   <= '0;
                        done     <= 1'b0;
                        state    <= READ;
                    end
                end
                READ: begin
                    // Synchronous memory: data for the address of cycle k arrives in cycle k+1.
                    if (rd_cnt != '0) header[rd_cnt - 1'b1] <= mem_read_data;
                    if (rd_cnt < RW'(NUM_OF_WORDS - 1)) mem_addr <= mem_addr + 16'd1;
                    if (rd_cnt == RW'(NUM_OF_WORDS)) begin
                        blk   <= '0;
                        state <= INIT;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                INIT: begin
                    for (int i = 0; i < 8; i++) v[i] <= (blk == '0) ? IV[i] : mid[i];
                    if (blk == '0) begin
                        for (int i = 0; i < 16; i++) w[i] <= header[i];
                    end else begin
                        w[0] <= header[16];
                        w[1] <= header[17];
                        w[2] <= header[18];
                        w[3] <= 32'(nidx);
                        w[4] <= 32'h8000_0000;
                        for (int i = 5; i < 15; i++) w[i] <= '0;
                        w[15] <= 32'h0000_0280;
                    end
                    t     <= '0;
                    state <= ROUND;
                end
                ROUND: begin
                    v[0] <= t1 + t2;
                    v[1] <= v[0];
                    v[2] <= v[1];
                    v[3] <= v[2];
                    v[4] <= v[3] + t1;
                    v[5] <= v[4];
                    v[6] <= v[5];
                    v[7] <= v[6];
                    for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                    w[15] <= w_new;
                    t     <= t + 6'd1;
                    if (t == 6'd63) state <= ADD;
                end
                ADD: begin
                    if (blk == '0) begin
                        for (int i = 0; i < 8; i++) mid[i] <= sum[i];
                    end else begin
                        for (int i = 0; i < 8; i++) hout[nidx][i] <= sum[i];
                    end
                    if (blk < BW'(NUM_NONCES)) begin
                        blk   <= blk + 1'b1;
                        state <= INIT;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_nonce_sweep.sv
// Directed bench: reference SHA-256 compression fills a scoreboard queue per run;
// a negedge monitor pops and compares when done rises.
module tb_sha256_nonce_sweep;
    localparam int NN = 16;
    localparam int LAT = 1142;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] input_addr;
    logic [31:0] mem_read_data;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] hout [NN][8];

    logic [31:0]  mem [65536];
    logic [255:0] exp_q[$];
    int           exp_done_q[$];
    int           cyc;
    int           n_checks;
    int           n_fail;
    bit           done_prev;
    bit           we_seen;

    localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic [31:0] kt [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    sha256_nonce_sweep #(.NUM_OF_WORDS(19), .NUM_NONCES(NN)) dut (
        .clk(clk), .reset(reset), .start(start), .input_addr(input_addr),
        .mem_read_data(mem_read_data), .done(done), .mem_clk(mem_clk),
        .mem_we(mem_we), .mem_addr(mem_addr), .hout(hout));

    // Clock/reset, cycle counter and synchronous-read memory
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_read_data <= mem[mem_addr];

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression with a full 64-word schedule
    function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        {a, b, c, d, e, f, g, h} = st;
        for (int i = 0; i < 64; i++) begin
            x1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + kt[i] + w[i];
            x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
        end
        return {a + st[255:224], b + st[223:192], c + st[191:160], d + st[159:128],
                e + st[127:96],  f + st[95:64],   g + st[63:32],   h + st[31:0]};
    endfunction

    function automatic logic [255:0] pack(input int n);
        logic [255:0] p = '0;
        for (int i = 0; i < 8; i++) p = {p[223:0], hout[n][i]};
        return p;
    endfunction

    function automatic bit hout_zero();
        bit z = 1'b1;
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < 8; i++) if (hout[n][i] != 32'h0) z = 1'b0;
        return z;
    endfunction

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_expected(input logic [15:0] base);
        logic [31:0]  hdr [19];
        logic [511:0] m1;
        logic [255:0] ms;
        logic [15:0]  a;
        for (int k = 0; k < 19; k++) begin
            a = base + 16'(k);
            hdr[k] = mem[a];
        end
        for (int k = 0; k < 16; k++) m1[511 - 32*k -: 32] = hdr[k];
        ms = compress(IV256, m1);
        for (int n = 0; n < NN; n++)
            exp_q.push_back(compress(ms, {hdr[16], hdr[17], hdr[18], 32'(n), 32'h80000000, 320'b0, 32'h280}));
        exp_done_q.push_back(cyc + 1 + LAT);
    endtask

    // Driver: one start pulse, optional address trace check and re-pulses, bounded wait
    task automatic run(input logic [15:0] base, input bit chk_addr, input bit repulse);
        @(negedge clk);
        input_addr = base;
        start = 1'b1;
        push_expected(base);
        @(negedge clk);
        check(done == 1'b0, "done_fall", 256'(done), 256'(0));
        for (int c = 0; c < LAT + 150 && exp_done_q.size() != 0; c++) begin
            if (chk_addr && c < 19)
                check(mem_addr == base + 16'(c), $sformatf("mem_addr_c%0d", c), 256'(mem_addr), 256'(base + 16'(c)));
            start = repulse && (c == 5 || c == 600);
            @(negedge clk);
        end
        start = 1'b0;
        if (exp_done_q.size() != 0) begin
            check(1'b0, "done_timeout", 256'(done), 256'(1));
            exp_q.delete();
            exp_done_q.delete();
        end
    endtask

    // Monitor: on each done rise pop the latency and per-nonce hashes
    always @(negedge clk) begin
        if (mem_we) we_seen = 1'b1;
        if (!reset && done && !done_prev && exp_done_q.size() > 0) begin
            int ec;
            logic [255:0] eh;
            ec = exp_done_q.pop_front();
            check(cyc == ec, "done_latency", 256'(cyc), 256'(ec));
            for (int n = 0; n < NN; n++) begin
                eh = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check(pack(n) == eh, $sformatf("hout_%0d", n), pack(n), eh);
            end
        end
        done_prev = done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        reset = 1'b1;
        start = 1'b0;
        input_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check(done == 1'b1, "reset_done", 256'(done), 256'(1));
        check(mem_addr == 16'h0, "reset_mem_addr", 256'(mem_addr), 256'(0));
        check(hout_zero(), "reset_hout_zero", 256'(hout_zero()), 256'(1));
        reset = 1'b0;

        // Reference model sanity: SHA-256("abc")
        check(compress(IV256, {32'h61626380, 448'b0, 32'h18}) ==
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
              "model_abc", compress(IV256, {32'h61626380, 448'b0, 32'h18}),
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        // Header words 0..18 at 0x0100
        for (int i = 0; i < 19; i++) mem[16'h0100 + i] = 32'(i);
        run(16'h0100, 1'b1, 1'b0);

        // Abort during the ROUND phase of nonce 7
        @(negedge clk);
        input_addr = 16'h0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (579) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check(done == 1'b1, "abort_done", 256'(done), 256'(1));
        check(mem_addr == 16'h0, "abort_mem_addr", 256'(mem_addr), 256'(0));
        check(hout_zero(), "abort_hout_zero", 256'(hout_zero()), 256'(1));
        @(negedge clk);
        reset = 1'b0;

        // All-zero header at 0x0200
        run(16'h0200, 1'b0, 1'b0);
        check(pack(15) != pack(14), "zero_hdr_h15_ne_h14", pack(15), pack(14));

        // Address wrap from 0xFFF0
        for (int i = 0; i < 19; i++) begin
            a = 16'hFFF0 + 16'(i);
            mem[a] = 32'h9e3779b9 * 32'(i + 1);
        end
        run(16'hFFF0, 1'b1, 1'b0);

        // start re-pulsed mid-run must be ignored
        for (int i = 0; i < 19; i++) mem[16'h0300 + i] = 32'h01234567 ^ (32'(i) << 8) ^ 32'(i * 7);
        run(16'h0300, 1'b0, 1'b1);

        check(!we_seen, "mem_we_low", 256'(we_seen), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
